// File: rtl/uart_stream_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_stream_fifo_pkg: overflow-policy encodings and drop-counter helper.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_stream_fifo_pkg;

  localparam int FIFO_OVF_DROP      = 0;
  localparam int FIFO_OVF_OVERWRITE = 1;
  localparam int DROP_CNT_WIDTH     = 16;

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_sdp_ram.sv
// ---------------------------------------------------------------------------
// fifo_sdp_ram: simple dual-port RAM, one write port, registered read-first read port.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_sdp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (write_en) mem[write_addr] <= write_data;
  end

  // Non-blocking update makes a same-address read return the old entry.
  always_ff @(posedge clk) begin
    if (rst)          read_data <= '0;
    else if (read_en) read_data <= mem[read_addr];
  end

endmodule

`default_nettype wire

// File: rtl/uart_stream_fifo.sv
// ---------------------------------------------------------------------------
// uart_stream_fifo: parametrised stream FIFO with occupancy flags and drop counter.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_stream_fifo
  import uart_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int OVERFLOW_MODE = FIFO_OVF_DROP,
  parameter int AFULL_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int AEMPTY_LEVEL  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      write_strobe,
  input  logic [DATA_WIDTH-1:0]     write_data,
  input  logic                      read_strobe,
  output logic [DATA_WIDTH-1:0]     read_data,
  output logic                      read_valid,
  output logic [ADDR_WIDTH:0]       count,
  output logic [ADDR_WIDTH:0]       write_available,
  output logic [ADDR_WIDTH:0]       size,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      overflow,
  output logic                      underflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_V   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_V   = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_V  = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);
  localparam bit                  OVERWRITE = (OVERFLOW_MODE == FIFO_OVF_OVERWRITE);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  wr_full_hit;
  logic                  overwrite;

  assign full            = (count == DEPTH_V);
  assign empty           = (count == '0);
  assign almost_full     = (count >= AFULL_V);
  assign almost_empty    = (count <= AEMPTY_V);
  assign write_available = DEPTH_V - count;
  assign size            = DEPTH_V;

  // A read accepted in the same cycle frees the slot, so a full FIFO still takes the write.
  assign rd_accept   = read_strobe && !empty && !flush && !rst;
  assign wr_full_hit = write_strobe && full && !rd_accept && !flush && !rst;
  assign overwrite   = wr_full_hit && OVERWRITE;
  assign wr_accept   = write_strobe && !flush && !rst && (!full || rd_accept || OVERWRITE);

  fifo_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk        (clk),
    .rst        (rst),
    .write_en   (wr_accept),
    .write_addr (wr_ptr),
    .write_data (write_data),
    .read_en    (rd_accept),
    .read_addr  (rd_ptr),
    .read_data  (read_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      read_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      drop_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      read_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      read_valid <= rd_accept;
      underflow  <= read_strobe && empty;
      overflow   <= wr_full_hit;
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept || overwrite) rd_ptr <= rd_ptr + 1'b1;
      if (wr_full_hit) drop_count <= sat_inc(drop_count);
      if (wr_accept && !rd_accept && !overwrite) count <= count + 1'b1;
      else if (rd_accept && !wr_accept)          count <= count - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_stream_fifo: directed vector table plus corner-case sequences, depth 4, both modes.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_stream_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  logic       wr0 = 1'b0, rd0 = 1'b0;
  logic [7:0] wd0 = '0;
  logic [7:0] rdat0;
  logic       rv0, full0, empty0, af0, ae0, ovf0, udf0;
  logic [2:0] cnt0, wa0, sz0;
  logic [15:0] drop0;

  logic       wr1 = 1'b0, rd1 = 1'b0;
  logic [7:0] wd1 = '0;
  logic [7:0] rdat1;
  logic       rv1, full1, empty1, af1, ae1, ovf1, udf1;
  logic [2:0] cnt1, wa1, sz1;
  logic [15:0] drop1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_stream_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .OVERFLOW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .write_strobe(wr0), .write_data(wd0), .read_strobe(rd0),
    .read_data(rdat0), .read_valid(rv0), .count(cnt0),
    .write_available(wa0), .size(sz0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .overflow(ovf0),
    .underflow(udf0), .drop_count(drop0)
  );

  uart_stream_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .OVERFLOW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .write_strobe(wr1), .write_data(wd1), .read_strobe(rd1),
    .read_data(rdat1), .read_valid(rv1), .count(cnt1),
    .write_available(wa1), .size(sz1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .overflow(ovf1),
    .underflow(udf1), .drop_count(drop1)
  );

  typedef struct {
    logic        r, f, w;
    logic [7:0]  wd;
    logic        rd;
    int          cnt;
    logic        rv;
    logic [7:0]  rdat;
    logic        ovf, udf;
    logic [15:0] drop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, f, w, input logic [7:0] wd, input logic rd,
                     input int cnt, input logic rv, input logic [7:0] rdat,
                     input logic ovf, udf, input logic [15:0] drop);
    vec_t v;
    v.r = r; v.f = f; v.w = w; v.wd = wd; v.rd = rd; v.cnt = cnt;
    v.rv = rv; v.rdat = rdat; v.ovf = ovf; v.udf = udf; v.drop = drop;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk1(input string name, input int cnt, input logic rv, input logic [7:0] rdat,
                      input logic ovf, input logic [15:0] drop);
    chk({name, " count"}, 32'(cnt1), 32'(cnt));
    chk({name, " read_valid"}, 32'(rv1), 32'(rv));
    chk({name, " read_data"}, 32'(rdat1), 32'(rdat));
    chk({name, " overflow"}, 32'(ovf1), 32'(ovf));
    chk({name, " drop_count"}, 32'(drop1), 32'(drop));
  endtask

  task automatic fill1();
    for (int k = 0; k < 4; k++) begin
      wr1 = 1'b1; wd1 = 8'(8'h11 * (k + 1));
      tick();
    end
    wr1 = 1'b0;
    chk("mode1 fill count", 32'(cnt1), 32'd4);
  endtask

  logic [7:0] exp_ovw [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] exp_rw  [4] = '{8'h22, 8'h33, 8'h44, 8'h66};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   r f w  wd    rd  cnt rv rdat  ov ud drop
    add(1,0,0, 8'h00, 0,  0, 0, 8'h00, 0, 0, 16'd0);
    add(0,0,1, 8'h11, 0,  1, 0, 8'h00, 0, 0, 16'd0);
    add(0,0,1, 8'h22, 0,  2, 0, 8'h00, 0, 0, 16'd0);
    add(0,0,1, 8'h33, 0,  3, 0, 8'h00, 0, 0, 16'd0);
    add(0,0,1, 8'h44, 0,  4, 0, 8'h00, 0, 0, 16'd0);
    add(0,0,1, 8'h55, 0,  4, 0, 8'h00, 1, 0, 16'd1);
    add(0,0,0, 8'h00, 0,  4, 0, 8'h00, 0, 0, 16'd1);
    add(0,0,0, 8'h00, 1,  3, 1, 8'h11, 0, 0, 16'd1);
    add(0,0,0, 8'h00, 1,  2, 1, 8'h22, 0, 0, 16'd1);
    add(0,0,0, 8'h00, 1,  1, 1, 8'h33, 0, 0, 16'd1);
    add(0,0,0, 8'h00, 1,  0, 1, 8'h44, 0, 0, 16'd1);
    add(0,0,0, 8'h00, 1,  0, 0, 8'h44, 0, 1, 16'd1);
    add(0,0,0, 8'h00, 0,  0, 0, 8'h44, 0, 0, 16'd1);
    add(0,0,1, 8'h11, 0,  1, 0, 8'h44, 0, 0, 16'd1);
    add(0,0,1, 8'h22, 0,  2, 0, 8'h44, 0, 0, 16'd1);
    add(0,0,1, 8'h33, 0,  3, 0, 8'h44, 0, 0, 16'd1);
    add(0,0,1, 8'h44, 0,  4, 0, 8'h44, 0, 0, 16'd1);
    add(0,0,1, 8'h66, 1,  4, 1, 8'h11, 0, 0, 16'd1);
    add(0,0,0, 8'h00, 1,  3, 1, 8'h22, 0, 0, 16'd1);
    add(0,0,0, 8'h00, 1,  2, 1, 8'h33, 0, 0, 16'd1);
    add(0,0,0, 8'h00, 1,  1, 1, 8'h44, 0, 0, 16'd1);
    add(0,0,0, 8'h00, 1,  0, 1, 8'h66, 0, 0, 16'd1);
    add(0,0,1, 8'h77, 1,  1, 0, 8'h66, 0, 1, 16'd1);
    add(0,0,0, 8'h00, 1,  0, 1, 8'h77, 0, 0, 16'd1);
    add(0,0,1, 8'h01, 0,  1, 0, 8'h77, 0, 0, 16'd1);
    add(0,0,1, 8'h02, 0,  2, 0, 8'h77, 0, 0, 16'd1);
    add(0,1,1, 8'h03, 0,  0, 0, 8'h77, 0, 0, 16'd1);
    add(0,0,0, 8'h00, 1,  0, 0, 8'h77, 0, 1, 16'd1);
    add(1,0,0, 8'h00, 0,  0, 0, 8'h00, 0, 0, 16'd0);

    foreach (vecs[i]) begin
      rst = vecs[i].r; flush = vecs[i].f;
      wr0 = vecs[i].w; wd0 = vecs[i].wd; rd0 = vecs[i].rd;
      tick();
      chk($sformatf("v%0d count", i),        32'(cnt0),  32'(vecs[i].cnt));
      chk($sformatf("v%0d read_valid", i),   32'(rv0),   32'(vecs[i].rv));
      chk($sformatf("v%0d read_data", i),    32'(rdat0), 32'(vecs[i].rdat));
      chk($sformatf("v%0d overflow", i),     32'(ovf0),  32'(vecs[i].ovf));
      chk($sformatf("v%0d underflow", i),    32'(udf0),  32'(vecs[i].udf));
      chk($sformatf("v%0d drop_count", i),   32'(drop0), 32'(vecs[i].drop));
      chk($sformatf("v%0d full", i),         32'(full0), 32'(vecs[i].cnt == 4));
      chk($sformatf("v%0d empty", i),        32'(empty0), 32'(vecs[i].cnt == 0));
      chk($sformatf("v%0d almost_full", i),  32'(af0),   32'(vecs[i].cnt >= 3));
      chk($sformatf("v%0d almost_empty", i), 32'(ae0),   32'(vecs[i].cnt <= 1));
      chk($sformatf("v%0d write_avail", i),  32'(wa0),   32'(4 - vecs[i].cnt));
      chk($sformatf("v%0d size", i),         32'(sz0),   32'd4);
    end
    rst = 1'b0; flush = 1'b0; wr0 = 1'b0; rd0 = 1'b0;

    // Wrap: ten write/read pairs walk the pointers around the ring more than twice.
    for (int i = 0; i < 10; i++) begin
      wr0 = 1'b1; wd0 = 8'(i);
      tick();
      wr0 = 1'b0;
      chk($sformatf("wrap%0d count after write", i), 32'(cnt0), 32'd1);
      chk($sformatf("wrap%0d overflow", i), 32'(ovf0), 32'd0);
      rd0 = 1'b1;
      tick();
      rd0 = 1'b0;
      chk($sformatf("wrap%0d read_data", i), 32'(rdat0), 32'(i));
      chk($sformatf("wrap%0d read_valid", i), 32'(rv0), 32'd1);
      chk($sformatf("wrap%0d count after read", i), 32'(cnt0), 32'd0);
      chk($sformatf("wrap%0d underflow", i), 32'(udf0), 32'd0);
    end
    tick();
    chk("wrap read_valid pulse ends", 32'(rv0), 32'd0);

    // Overwrite mode: incoming word displaces the oldest entry.
    rst = 1'b1; tick(); rst = 1'b0;
    fill1();
    wr1 = 1'b1; wd1 = 8'h55;
    tick();
    wr1 = 1'b0;
    chk1("ovw write", 4, 1'b0, 8'h00, 1'b1, 16'd1);
    chk("ovw full", 32'(full1), 32'd1);
    tick();
    chk1("ovw idle", 4, 1'b0, 8'h00, 1'b0, 16'd1);
    for (int k = 0; k < 4; k++) begin
      rd1 = 1'b1;
      tick();
      chk1($sformatf("ovw read%0d", k), 3 - k, 1'b1, exp_ovw[k], 1'b0, 16'd1);
    end
    rd1 = 1'b0;

    // Overwrite mode, full with simultaneous read and write: plain accept, no overflow.
    fill1();
    rd1 = 1'b1; wr1 = 1'b1; wd1 = 8'h66;
    tick();
    wr1 = 1'b0;
    chk1("ovw rw full", 4, 1'b1, 8'h11, 1'b0, 16'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk1($sformatf("ovw rw read%0d", k), 3 - k, 1'b1, exp_rw[k], 1'b0, 16'd1);
    end
    rd1 = 1'b0;

    // Drop counter saturation under a continuous stream of overwrites.
    rst = 1'b1; tick(); rst = 1'b0;
    fill1();
    wr1 = 1'b1; wd1 = 8'hAA;
    repeat (65534) tick();
    chk("drop_count before saturation", 32'(drop1), 32'hFFFE);
    tick();
    chk("drop_count at saturation", 32'(drop1), 32'hFFFF);
    repeat (3) tick();
    chk("drop_count holds saturated", 32'(drop1), 32'hFFFF);
    chk("count during overwrite stream", 32'(cnt1), 32'd4);
    wr1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
